// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop family: S=R=1 policy codes and
// the per-bit next-state function used by every SR storage cell.
package sr_pkg;

    localparam int unsigned SR_RST_DOM = 32'd0;
    localparam int unsigned SR_SET_DOM = 32'd1;
    localparam int unsigned SR_HOLD    = 32'd2;
    localparam int unsigned SR_TOGGLE  = 32'd3;

    // Next-state for one SR bit. In the reset-dominant policy r is tested
    // first, so r=1 forces 0 even when s is unknown; this is what allows a
    // flop to be initialised by asserting r alone.
    function automatic logic sr_next(
        input logic        q,
        input logic        s,
        input logic        r,
        input int unsigned mode
    );
        logic next_s;
        next_s = q;
        case (mode)
            SR_SET_DOM: begin
                if (s)      next_s = 1'b1;
                else if (r) next_s = 1'b0;
                else        next_s = q;
            end
            SR_HOLD: begin
                if (s && r) next_s = q;
                else if (r) next_s = 1'b0;
                else if (s) next_s = 1'b1;
                else        next_s = q;
            end
            SR_TOGGLE: begin
                if (s && r) next_s = ~q;
                else if (r) next_s = 1'b0;
                else if (s) next_s = 1'b1;
                else        next_s = q;
            end
            default: begin
                if (r)      next_s = 1'b0;
                else if (s) next_s = 1'b1;
                else        next_s = q;
            end
        endcase
        return next_s;
    endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// Single-bit clocked SR cell: registered state, combinational complement,
// and a registered flag recording that S and R were both high at the last edge.
module sr_ff_bit
    import sr_pkg::*;
#(
    parameter logic        RST_VAL   = 1'b0,
    parameter int unsigned BOTH_MODE = SR_RST_DOM
) (
    input  logic clk,
    input  logic rst,
    input  logic s_in,
    input  logic r_in,
    output logic q_out,
    output logic q_comp,
    output logic sr_both
);

    logic q_r;
    logic both_r;

    // State and S=R=1 flag update; synchronous reset overrides s_in/r_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= RST_VAL;
            both_r <= 1'b0;
        end else begin
            q_r    <= sr_next(q_r, s_in, r_in, BOTH_MODE);
            both_r <= s_in & r_in;
        end
    end

    assign q_out   = q_r;
    assign q_comp  = ~q_r;
    assign sr_both = both_r;

endmodule

// File: rtl/sr_ff.sv
// Bank of WIDTH independent clocked SR flip-flops with complementary outputs
// and a per-bit registered S=R=1 flag.
module sr_ff
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH     = 32'd1,
    parameter logic        RST_VAL   = 1'b0,
    parameter int unsigned BOTH_MODE = SR_RST_DOM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_in,
    input  logic [WIDTH-1:0] r_in,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] q_comp,
    output logic [WIDTH-1:0] sr_both
);

    // Only the four defined S=R=1 policies are meaningful.
    if (BOTH_MODE > SR_TOGGLE) begin : g_bad_mode
        $fatal(1, "sr_ff: BOTH_MODE must be 0..3");
    end

    // One independent cell per bit; no cross-bit interaction.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        sr_ff_bit #(
            .RST_VAL   (RST_VAL),
            .BOTH_MODE (BOTH_MODE)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .s_in    (s_in[i]),
            .r_in    (r_in[i]),
            .q_out   (q_out[i]),
            .q_comp  (q_comp[i]),
            .sr_both (sr_both[i])
        );
    end

endmodule

// File: tb/tb_sr_ff.sv
// Self-checking bench for sr_ff: a 1-bit default-mode instance plus four
// 4-bit instances, one per S=R=1 policy, sharing clock and reset.
module tb_sr_ff;

    typedef struct packed {
        logic            q1;
        logic            b1;
        logic [3:0][3:0] m;
        logic [3:0]      b4;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            s1;
    logic            r1;
    logic            q1;
    logic            q1_comp;
    logic            b1;
    logic [3:0]      s4;
    logic [3:0]      r4;
    logic [3:0]      q_m    [4];
    logic [3:0]      qc_m   [4];
    logic [3:0]      b_m    [4];

    int   checks;
    int   failures;
    bit   comp_en;
    exp_t sb_q[$];
    exp_t got;

    sr_ff u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .s_in    (s1),
        .r_in    (r1),
        .q_out   (q1),
        .q_comp  (q1_comp),
        .sr_both (b1)
    );

    for (genvar g = 0; g < 4; g++) begin : g_mode
        sr_ff #(
            .WIDTH     (4),
            .RST_VAL   (1'b0),
            .BOTH_MODE (g)
        ) u_dut4 (
            .clk     (clk),
            .rst     (rst),
            .s_in    (s4),
            .r_in    (r4),
            .q_out   (q_m[g]),
            .q_comp  (qc_m[g]),
            .sr_both (b_m[g])
        );
    end

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // q_comp must equal ~q_out on every instance, every cycle.
    always @(negedge clk) begin
        if (comp_en) begin
            checks++;
            if (q1_comp !== ~q1) begin
                failures++;
                $display("FAIL q_comp_1bit: got %b expected %b", q1_comp, ~q1);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (qc_m[k] !== ~q_m[k]) begin
                    failures++;
                    $display("FAIL q_comp_mode%0d: got %b expected %b", k, qc_m[k], ~q_m[k]);
                end
            end
        end
    end

    // Drive one cycle of stimulus, record what it should produce, then
    // move to 1 ns after the edge where outputs are sampled.
    task automatic apply(input logic rst_v, input logic s1_v, input logic r1_v,
                         input logic [3:0] s4_v, input logic [3:0] r4_v, input exp_t e);
        rst = rst_v; s1 = s1_v; r1 = r1_v; s4 = s4_v; r4 = r4_v;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic q1_v, input logic b1_v,
                                input logic [3:0] m0, input logic [3:0] m1,
                                input logic [3:0] m2, input logic [3:0] m3,
                                input logic [3:0] b4_v);
        exp_t e;
        e.q1 = q1_v; e.b1 = b1_v;
        e.m[0] = m0; e.m[1] = m1; e.m[2] = m2; e.m[3] = m3;
        e.b4 = b4_v;
        return e;
    endfunction

    task automatic test_init_r();
        rst = 1'b0; s1 = 1'bx; r1 = 1'b1; s4 = 4'bxxxx; r4 = 4'b1111;
        sb_q.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        #11;
        got = sb_q.pop_front();
        checks++;
        if (q1 !== got.q1 || q1_comp !== 1'b1) begin
            failures++;
            $display("FAIL init_r_1bit: got q=%b qc=%b expected q=%b qc=1", q1, q1_comp, got.q1);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q_m[k] !== got.m[k]) begin
                failures++;
                $display("FAIL init_r_mode%0d: got %b expected %b", k, q_m[k], got.m[k]);
            end
        end
        comp_en = 1'b1;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, mk(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        got = sb_q.pop_front();
        checks++;
        if (q1 !== got.q1 || b1 !== got.b1) begin
            failures++;
            $display("FAIL reset_1bit: got q=%b b=%b expected q=%b b=%b", q1, b1, got.q1, got.b1);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q_m[k] !== got.m[k] || b_m[k] !== got.b4) begin
                failures++;
                $display("FAIL reset_mode%0d: got q=%b b=%b expected q=%b b=%b",
                         k, q_m[k], b_m[k], got.m[k], got.b4);
            end
        end
    endtask

    task automatic test_hold_set_reset();
        logic [2:0] s_tab = 3'b100;
        logic [2:0] r_tab = 3'b010;
        logic [2:0] q_tab = 3'b100;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, s_tab[i], r_tab[i], 4'h0, 4'h0, mk(q_tab[i], 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
            got = sb_q.pop_front();
            checks++;
            if (q1 !== got.q1 || b1 !== got.b1) begin
                failures++;
                $display("FAIL hold_set_reset[%0d]: got q=%b b=%b expected q=%b b=%b",
                         i, q1, b1, got.q1, got.b1);
            end
        end
        checks++;
        if (q1_comp !== 1'b0) begin
            failures++;
            $display("FAIL set_qcomp: got %b expected 0", q1_comp);
        end
    endtask

    task automatic test_both_default();
        logic [1:0] sr_tab = 2'b01;
        logic [1:0] b_tab  = 2'b01;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, sr_tab[i], sr_tab[i], 4'h0, 4'h0, mk(1'b0, b_tab[i], 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
            got = sb_q.pop_front();
            checks++;
            if (q1 !== got.q1 || b1 !== got.b1) begin
                failures++;
                $display("FAIL both_default[%0d]: got q=%b b=%b expected q=%b b=%b",
                         i, q1, b1, got.q1, got.b1);
            end
        end
    endtask

    task automatic test_sync_reset();
        apply(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, mk(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        got = sb_q.pop_front();
        checks++;
        if (q1 !== got.q1) begin
            failures++;
            $display("FAIL sync_reset_pre: got %b expected %b", q1, got.q1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (q1 !== 1'b1) begin
            failures++;
            $display("FAIL sync_reset_midcycle: got %b expected 1", q1);
        end
        sb_q.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        if (q1 !== got.q1) begin
            failures++;
            $display("FAIL sync_reset_edge: got %b expected %b", q1, got.q1);
        end
        apply(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, mk(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        got = sb_q.pop_front();
        checks++;
        if (q1 !== got.q1) begin
            failures++;
            $display("FAIL sync_reset_release: got %b expected %b", q1, got.q1);
        end
    endtask

    task automatic test_modes();
        logic [3:0] s_tab [4] = '{4'b0101, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] r_tab [4] = '{4'b1010, 4'b1111, 4'b1111, 4'b0000};
        exp_t       e_tab [4];
        e_tab[0] = mk(1'b1, 1'b0, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000);
        e_tab[1] = mk(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0101, 4'b1010, 4'b1111);
        e_tab[2] = mk(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0101, 4'b0101, 4'b1111);
        e_tab[3] = mk(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0101, 4'b0101, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b0, s_tab[i], r_tab[i], e_tab[i]);
            got = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q_m[k] !== got.m[k] || b_m[k] !== got.b4) begin
                    failures++;
                    $display("FAIL modes[%0d]_mode%0d: got q=%b b=%b expected q=%b b=%b",
                             i, k, q_m[k], b_m[k], got.m[k], got.b4);
                end
            end
        end
    endtask

    task automatic test_independence();
        logic [3:0] s_tab [2] = '{4'b0011, 4'b0100};
        logic [3:0] r_tab [2] = '{4'b1100, 4'b0001};
        logic [3:0] q_tab [2] = '{4'b0011, 4'b0110};
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0, s_tab[i], r_tab[i],
                  mk(1'b1, 1'b0, q_tab[i], q_tab[i], q_tab[i], q_tab[i], 4'b0000));
            got = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q_m[k] !== got.m[k] || qc_m[k] !== ~got.m[k] || b_m[k] !== got.b4) begin
                    failures++;
                    $display("FAIL independence[%0d]_mode%0d: got q=%b qc=%b b=%b expected q=%b qc=%b b=%b",
                             i, k, q_m[k], qc_m[k], b_m[k], got.m[k], ~got.m[k], got.b4);
                end
            end
        end
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        comp_en  = 1'b0;
        test_init_r();
        test_reset();
        test_hold_set_reset();
        test_both_default();
        test_sync_reset();
        test_modes();
        test_independence();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
